cozy_decoder: RTL and testbench

//  Fetch/decode/execute sequencer for the cozy core. Fetches 16-bit words over a
//  req/ack memory port, decodes them into the cozy_alu control set (op, rD/rS

---
 rtl/cozy_pkg.sv | 68 ++++++
 rtl/cozy_decoder.sv | 118 +++++++++++
 tb/tb_cozy_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cozy_pkg.sv
// cozy_pkg: shared definitions for the cozy core sequencer.
//  - instruction class codes (ir[15:12])
//  - sequencer state encoding
//  - cozy_alu op codes, in the ALU's own ordering
//  - decode(): pure combinational instruction decode
package cozy_pkg;

    localparam logic [3:0] CLS_ALU = 4'h0;
    localparam logic [3:0] CLS_CMP = 4'h1;
    localparam logic [3:0] CLS_LDI = 4'h2;
    localparam logic [3:0] CLS_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_IMM,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_OR, OP_AND, OP_XOR, OP_BIC,
        OP_ADD, OP_ADC, OP_SUB, OP_SBC,
        OP_NOT, OP_NEG, OP_INC, OP_DEC,
        OP_SHR, OP_SRC, OP_SHL, OP_SLC
    } alu_op_t;

    typedef struct packed {
        logic [3:0] rd;
        logic [3:0] rs;
        alu_op_t    op;
        logic       wb;         // register writeback in EXEC
        logic       wb_imm;     // writeback data comes from the immediate word
        logic       need_imm;   // a second word follows the instruction
        logic       carry_upd;  // carry <= alu_cout in EXEC
        logic       halt;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] ir);
        dec_t d;
        d.rd        = ir[11:8];
        d.rs        = ir[7:4];
        d.op        = alu_op_t'(ir[3:0]);
        d.wb        = 1'b0;
        d.wb_imm    = 1'b0;
        d.need_imm  = 1'b0;
        d.carry_upd = 1'b0;
        d.halt      = 1'b0;
        d.illegal   = 1'b0;
        case (ir[15:12])
            CLS_ALU: begin
                d.wb        = 1'b1;
                d.carry_upd = 1'b1;
            end
            CLS_CMP: d.carry_upd = 1'b1;
            CLS_LDI: begin
                d.wb       = 1'b1;
                d.wb_imm   = 1'b1;
                d.need_imm = 1'b1;
            end
            CLS_HLT: d.halt = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cozy_decoder.sv
// cozy_decoder: fetch/decode/execute sequencer for the cozy core.
// Fetches instruction words over a req/ack port, steers the external cozy_alu
// and register file, and owns PC and carry.
// Ports:
//  clk, rst_n            clock, async active-low reset
//  mem_addr/req          fetch address and request (held until mem_ack)
//  mem_ack/rdata         fetch completion and returned word
//  rd_sel/rs_sel/alu_op  register selects and ALU op, valid DECODE..EXEC
//  alu_cin/alu_cout      carry flag out to ALU, ALU carry back in
//  wb_en/wb_sel_imm      one-cycle writeback strobe and data select
//  imm_out               immediate word for LDI
//  halted/illegal        halt state, one-cycle undefined-class pulse
module cozy_decoder
    import cozy_pkg::*;
#(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic                mem_req,
    input  logic                mem_ack,
    input  logic [15:0]         mem_rdata,
    output logic [3:0]          rd_sel,
    output logic [3:0]          rs_sel,
    output logic [3:0]          alu_op,
    output logic                alu_cin,
    input  logic                alu_cout,
    output logic                wb_en,
    output logic                wb_sel_imm,
    output logic [15:0]         imm_out,
    output logic                halted,
    output logic                illegal
);

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n;
    logic [15:0]         ir, ir_n;
    logic [15:0]         imm, imm_n;
    logic                carry, carry_n;
    dec_t                dec;

    assign dec      = decode(ir);
    assign mem_addr = pc;
    assign alu_cin  = carry;
    assign imm_out  = imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            imm   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            imm   <= imm_n;
            carry <= carry_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        imm_n      = imm;
        carry_n    = carry;
        mem_req    = 1'b0;
        wb_en      = 1'b0;
        wb_sel_imm = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        rd_sel     = '0;
        rs_sel     = '0;
        alu_op     = '0;
        // Register-file/ALU steering is held from DECODE through EXEC.
        if (state == ST_DECODE || state == ST_IMM || state == ST_EXEC) begin
            rd_sel = dec.rd;
            rs_sel = dec.rs;
            alu_op = dec.op;
        end
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_n    = mem_rdata;
                    pc_n    = pc + PC_WIDTH'(1);
                    state_n = ST_DECODE;
                end
            end
            ST_DECODE: state_n = dec.need_imm ? ST_IMM : ST_EXEC;
            ST_IMM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    imm_n   = mem_rdata;
                    pc_n    = pc + PC_WIDTH'(1);
                    state_n = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wb_en      = dec.wb;
                wb_sel_imm = dec.wb_imm;
                illegal    = dec.illegal;
                if (dec.carry_upd) carry_n = alu_cout;
                state_n    = dec.halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_n = ST_FETCH;
        endcase
        // The register already sits in FETCH while reset is held; keep the
        // request quiet until reset is released.
        if (!rst_n) mem_req = 1'b0;
    end

endmodule

// File: tb/tb_cozy_decoder.sv
// tb_cozy_decoder: scoreboard bench for cozy_decoder. A memory model serves a
// small program starting at 'hFFFF; each acked word that should cause an
// EXEC-visible event (writeback or illegal) pushes its expected event, and the
// monitor pops and compares whenever wb_en or illegal is seen.
module tb_cozy_decoder;

    typedef struct packed {
        logic        wb;
        logic        sel;
        logic        ill;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  op;
        logic        cin;
        logic [15:0] imm;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [3:0]  rd_sel, rs_sel, alu_op;
    logic        alu_cin, alu_cout;
    logic        wb_en, wb_sel_imm, halted, illegal;
    logic [15:0] imm_out;

    int          checks = 0;
    int          errors = 0;
    bit          no_ack = 1'b0;
    int          wait_cnt = 0;
    int          dly;
    evt_t        got, exp_e;

    logic [15:0] mem     [logic [15:0]];
    evt_t        exp_tab [logic [15:0]];
    evt_t        sb[$];
    logic [15:0] exp_addr[$];

    always #5 clk = ~clk;

    // Tiny ALU stand-in: only SUB produces a carry.
    assign alu_cout = (alu_op == 4'h6);

    cozy_decoder #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rd_sel(rd_sel), .rs_sel(rs_sel), .alu_op(alu_op),
        .alu_cin(alu_cin), .alu_cout(alu_cout),
        .wb_en(wb_en), .wb_sel_imm(wb_sel_imm), .imm_out(imm_out),
        .halted(halted), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor first, then memory response, in one process so order is fixed.
    always @(negedge clk) begin
        if (wb_en || illegal) begin
            got = '{wb: wb_en, sel: wb_sel_imm, ill: illegal, rd: rd_sel, rs: rs_sel,
                    op: alu_op, cin: alu_cin, imm: (wb_sel_imm ? imm_out : 16'h0)};
            if (sb.size() == 0) chk("sb_unexpected", 64'(got), 64'(0));
            else begin
                exp_e = sb.pop_front();
                chk("sb_evt", 64'(got), 64'(exp_e));
            end
        end
        mem_ack = 1'b0;
        dly = (mem_addr == 16'h2 || mem_addr == 16'h3) ? 3 : 0;
        if (mem_req && !no_ack) begin
            if (wait_cnt == dly) begin
                mem_ack   = 1'b1;
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'hF000;
                if (exp_addr.size() == 0) chk("fetch_addr_extra", 64'(mem_addr), 64'hDEAD);
                else chk("fetch_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
                if (exp_tab.exists(mem_addr)) sb.push_back(exp_tab[mem_addr]);
                wait_cnt = 0;
            end else wait_cnt++;
        end else wait_cnt = 0;
    end

    initial begin
        // Program: illegal-class NOP at the wrap point, ADD, CMP, LDI+imm, illegal, HLT.
        mem[16'hFFFF] = 16'h3000;
        mem[16'h0000] = 16'h0124;
        mem[16'h0001] = 16'h1126;
        mem[16'h0002] = 16'h2300;
        mem[16'h0003] = 16'hBEEF;
        mem[16'h0004] = 16'h7123;
        mem[16'h0005] = 16'hF000;
        exp_tab[16'hFFFF] = '{wb:0, sel:0, ill:1, rd:0, rs:0, op:0, cin:0, imm:0};
        exp_tab[16'h0000] = '{wb:1, sel:0, ill:0, rd:1, rs:2, op:4, cin:0, imm:0};
        exp_tab[16'h0003] = '{wb:1, sel:1, ill:0, rd:3, rs:0, op:0, cin:1, imm:16'hBEEF};
        exp_tab[16'h0004] = '{wb:0, sel:0, ill:1, rd:1, rs:2, op:3, cin:1, imm:0};
        exp_addr.push_back(16'hFFFF);
        for (int a = 0; a < 6; a++) exp_addr.push_back(16'(a));

        repeat (2) @(negedge clk);
        chk("reset_outs", {mem_req, wb_en, wb_sel_imm, illegal, halted, alu_op,
                           rd_sel, rs_sel, alu_cin, imm_out}, '0);
        chk("reset_pc", 64'(mem_addr), 64'hFFFF);

        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("req_after_rst", {mem_req, mem_addr}, {1'b1, 16'hFFFF});

        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        chk("halted", 64'(halted), 64'h1);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        chk("addr_drained", 64'(exp_addr.size()), 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_idle", {halted, mem_req, wb_en}, 3'b100);
        end

        // Reset out of HALT into a fetch that memory never answers.
        no_ack = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("refetch", {mem_req, mem_addr, halted, alu_cin}, {1'b1, 16'hFFFF, 2'b00});
        repeat (2) @(negedge clk);
        chk("fetch_held", {mem_req, mem_addr}, {1'b1, 16'hFFFF});

        // Reset mid-fetch abandons the request.
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midfetch_rst_outs", {mem_req, wb_en, wb_sel_imm, illegal, halted, alu_op,
                                  rd_sel, rs_sel, alu_cin, imm_out}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("restart", {mem_req, mem_addr, alu_cin}, {1'b1, 16'hFFFF, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
